vga_color_ctrl: RTL

VGA_COLOR_CTRL -- requirements
Module: vga_color_ctrl

---
 rtl/vga_pkg.sv | 29 ++
 rtl/vga_color_ctrl_btn_debounce.sv | 80 ++++++++
 rtl/vga_color_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
//
// Shared constants and types for the VGA colour controller slice.
//   * 640x480@60 timing constants, used as parameter defaults by
//     vga_color_ctrl (counter width and the inclusive visible window).
//   * Channel enumeration used to index the per-channel level registers.
// -----------------------------------------------------------------------------
package vga_pkg;

    // Width of the h/v pixel counters delivered by the sync generator.
    localparam int VGA_CNT_W = 11;

    // Inclusive visible window for 640x480 (800x525 total frame).
    localparam int VGA_H_START = 144;
    localparam int VGA_H_END   = 783;
    localparam int VGA_V_START = 35;
    localparam int VGA_V_END   = 514;

    // Channel index into the level/button arrays.
    typedef enum int {
        CH_R = 0,
        CH_G = 1,
        CH_B = 2
    } chan_e;

    localparam int NUM_CH = 3;

endpackage : vga_pkg

// File: rtl/vga_color_ctrl_btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//
// Turns one asynchronous raw push button into a single-cycle press pulse:
// 2-flop synchroniser -> stability-counting debouncer -> rising-edge detect.
//
// A held button produces exactly one pulse; a press therefore reaches the
// consumer's register DEBOUNCE_CYC+3 edges after the first sampling edge:
//   edge 0..1          : synchroniser fills
//   edge 2..DEBOUNCE_CYC+1 : counter sees DEBOUNCE_CYC differing cycles, flips
//   edge DEBOUNCE_CYC+2: registered edge detect raises press_o
//   edge DEBOUNCE_CYC+3: consumer samples press_o
//
// Ports
//   clk_i   : system clock
//   rst_i   : asynchronous active-high reset (clears every flop)
//   btn_i   : raw asynchronous button
//   press_o : one-cycle pulse on each debounced press (release gives none)
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 250000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic press_o
);

    // Counter only needs to reach DEBOUNCE_CYC-1; keep at least one bit.
    localparam int DB_CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [DB_CW-1:0] DB_LAST = DB_CW'(DEBOUNCE_CYC - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic [DB_CW-1:0] cnt_q;
    logic [DB_CW-1:0] cnt_d;
    logic             db_q;
    logic             db_d;
    logic             db_prev_q;
    logic             press_q;
    logic             press_d;

    // Counter runs only while the synchronised input disagrees with the
    // accepted state; any agreeing cycle restarts the stability window.
    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        if (sync2_q != db_q) begin
            if (cnt_q == DB_LAST) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Rising edge of the debounced state only; releases are ignored.
    assign press_d = db_q & ~db_prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            cnt_q     <= '0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            press_q   <= 1'b0;
        end else begin
            sync1_q   <= btn_i;
            sync2_q   <= sync1_q;
            cnt_q     <= cnt_d;
            db_q      <= db_d;
            db_prev_q <= db_q;
            press_q   <= press_d;
        end
    end

    assign press_o = press_q;

endmodule : btn_debounce

// File: rtl/vga_color_ctrl.sv
// -----------------------------------------------------------------------------
// vga_color_ctrl
//
// Holds one brightness level per colour channel, stepped by debounced push
// buttons, and drives it onto the VGA colour outputs inside the visible
// window (black during blanking).
//
// Ports
//   clk                 : pixel/system clock, all state on rising edge
//   reset               : asynchronous active-high reset
//   h_counter/v_counter : current pixel position from the sync generator
//   btn_r/btn_g/btn_b   : raw asynchronous channel buttons
//   dir                 : 0 = press increments, 1 = press decrements
//   level_clr           : one-cycle clear of all levels (beats any press)
//   vga_r/vga_g/vga_b   : registered colour outputs
//   active              : registered visible-window flag, aligned with vga_*
// -----------------------------------------------------------------------------
module vga_color_ctrl
    import vga_pkg::*;
#(
    parameter int COLOR_W      = 4,
    parameter int CNT_W        = VGA_CNT_W,
    parameter int H_START      = VGA_H_START,
    parameter int H_END        = VGA_H_END,
    parameter int V_START      = VGA_V_START,
    parameter int V_END        = VGA_V_END,
    parameter int SAT_MODE     = 0,
    parameter int DEBOUNCE_CYC = 250000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [CNT_W-1:0]   h_counter,
    input  logic [CNT_W-1:0]   v_counter,
    input  logic               btn_r,
    input  logic               btn_g,
    input  logic               btn_b,
    input  logic               dir,
    input  logic               level_clr,
    output logic [COLOR_W-1:0] vga_r,
    output logic [COLOR_W-1:0] vga_g,
    output logic [COLOR_W-1:0] vga_b,
    output logic               active
);

    localparam logic [COLOR_W-1:0] LVL_MAX = {COLOR_W{1'b1}};

    localparam logic [CNT_W-1:0] H_LO = CNT_W'(H_START);
    localparam logic [CNT_W-1:0] H_HI = CNT_W'(H_END);
    localparam logic [CNT_W-1:0] V_LO = CNT_W'(V_START);
    localparam logic [CNT_W-1:0] V_HI = CNT_W'(V_END);

    // One step of a channel level; SAT_MODE selects wrap or clamp at the ends.
    function automatic logic [COLOR_W-1:0] step_level(
        input logic [COLOR_W-1:0] lvl,
        input logic               down
    );
        logic [COLOR_W-1:0] res;
        if (!down) begin
            if (lvl == LVL_MAX) begin
                res = (SAT_MODE != 0) ? LVL_MAX : '0;
            end else begin
                res = lvl + 1'b1;
            end
        end else begin
            if (lvl == '0) begin
                res = (SAT_MODE != 0) ? '0 : LVL_MAX;
            end else begin
                res = lvl - 1'b1;
            end
        end
        return res;
    endfunction

    logic [NUM_CH-1:0]  btn_raw;
    logic [NUM_CH-1:0]  press;

    logic [COLOR_W-1:0] level_q [NUM_CH];
    logic [COLOR_W-1:0] level_d [NUM_CH];

    logic               in_win;
    logic [COLOR_W-1:0] vga_r_q;
    logic [COLOR_W-1:0] vga_r_d;
    logic [COLOR_W-1:0] vga_g_q;
    logic [COLOR_W-1:0] vga_g_d;
    logic [COLOR_W-1:0] vga_b_q;
    logic [COLOR_W-1:0] vga_b_d;
    logic               active_q;

    assign btn_raw = {btn_b, btn_g, btn_r};

    // Button front ends, one per channel.
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
        ) u_btn_debounce (
            .clk_i   (clk),
            .rst_i   (reset),
            .btn_i   (btn_raw[ch]),
            .press_o (press[ch])
        );
    end

    // Level update: clear wins over any coincident press; channels are
    // independent so several may step in the same cycle.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            level_d[c] = level_q[c];
            if (level_clr) begin
                level_d[c] = '0;
            end else if (press[c]) begin
                level_d[c] = step_level(level_q[c], dir);
            end
        end
    end

    // Visible window is inclusive on both ends.
    assign in_win = (h_counter >= H_LO) && (h_counter <= H_HI) &&
                    (v_counter >= V_LO) && (v_counter <= V_HI);

    // Blanking only masks the outputs; stored levels are untouched.
    always_comb begin
        vga_r_d = '0;
        vga_g_d = '0;
        vga_b_d = '0;
        if (in_win) begin
            vga_r_d = level_q[CH_R];
            vga_g_d = level_q[CH_G];
            vga_b_d = level_q[CH_B];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                level_q[c] <= '0;
            end
            vga_r_q  <= '0;
            vga_g_q  <= '0;
            vga_b_q  <= '0;
            active_q <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                level_q[c] <= level_d[c];
            end
            vga_r_q  <= vga_r_d;
            vga_g_q  <= vga_g_d;
            vga_b_q  <= vga_b_d;
            active_q <= in_win;
        end
    end

    assign vga_r  = vga_r_q;
    assign vga_g  = vga_g_q;
    assign vga_b  = vga_b_q;
    assign active = active_q;

endmodule : vga_color_ctrl
